alu_seq16: RTL and testbench

Multi-cycle controller that performs 16-bit add and subtract by sequencing the 8-bit ALU three times at most: low byte, high byte, and a conditional carry/borrow fix-up. It drives the ALU operand, subtract and active-low output-enable inputs, and captures results from the data bus and the ALU's registered carry flag. It sits between the control unit, which issues one 16-bit request at a time, and the ALU.

---
 rtl/nic8_alu_pkg.sv | 35 +++
 rtl/alu_seq16_if.sv | 22 ++
 rtl/alu_seq16.sv | 146 ++++++++++++++
 tb/tb_alu_seq16.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nic8_alu_pkg.sv
// nic8_alu_pkg: state encodings, op codes and the final carry
// combine rule shared by the 16-bit add/sub sequencer.
package nic8_alu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Folds the high-byte and fix-up carries into the 16-bit carry.
    // Add: a carry from either step carries out of bit 15.
    // Sub: carry means no borrow, so both steps must be borrow-free.
    function automatic logic carry_combine(
        input logic op,
        input logic fix,
        input logic c_hi,
        input logic c_fin
    );
        logic c;
        if (!fix)
            c = c_fin;
        else if (op == OP_SUB)
            c = c_hi & c_fin;
        else
            c = c_hi | c_fin;
        return c;
    endfunction

endpackage

// File: rtl/alu_seq16_if.sv
// alu_seq16_if: bus between the sequencer (master) and the 8-bit ALU
// (slave): operands, subtract select, active-low enable, result, carry.
interface alu_seq16_if;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_sub;
    logic       alu_assert_bar_e;
    logic [7:0] alu_dbus;
    logic       alu_carry;

    modport master (
        output alu_a, alu_b, alu_sub, alu_assert_bar_e,
        input  alu_dbus, alu_carry
    );

    modport slave (
        input  alu_a, alu_b, alu_sub, alu_assert_bar_e,
        output alu_dbus, alu_carry
    );

endinterface

// File: rtl/alu_seq16.sv
// alu_seq16: 16-bit add/sub built from up to three passes of the 8-bit
// ALU (low byte, high byte, carry/borrow fix-up).
// Ports: clk, reset (async, active low); request side req/op_sub/a/b,
// ready/done/result/cout; ALU side through alu_seq16_if.master alu.
module alu_seq16
    import nic8_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op_sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    alu_seq16_if.master alu
);

    state_t      state;
    state_t      state_nx;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        op_q;
    logic [7:0]  res_lo;
    logic [7:0]  res_hi;
    logic        c_lo;
    logic        c_hi;
    logic        fix;
    logic        fix_now;

    logic [7:0]  drv_a;
    logic [7:0]  drv_b;
    logic        drv_sub;
    logic        drv_en_n;

    // Low-byte carry needs a fix-up when an add carried, or a
    // subtract borrowed (ALU carry low).
    assign fix_now = (op_q == OP_ADD) ? alu.alu_carry : ~alu.alu_carry;
    assign fix     = (op_q == OP_ADD) ? c_lo : ~c_lo;

    assign ready = (state == S_IDLE);

    assign alu.alu_a            = drv_a;
    assign alu.alu_b            = drv_b;
    assign alu.alu_sub          = drv_sub;
    assign alu.alu_assert_bar_e = drv_en_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        drv_a    = 8'h00;
        drv_b    = 8'h00;
        drv_sub  = 1'b0;
        drv_en_n = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (req)
                    state_nx = S_LO;
            end
            S_LO: begin
                drv_a    = a_q[7:0];
                drv_b    = b_q[7:0];
                drv_sub  = op_q;
                drv_en_n = 1'b0;
                state_nx = S_HI;
            end
            S_HI: begin
                drv_a    = a_q[15:8];
                drv_b    = b_q[15:8];
                drv_sub  = op_q;
                drv_en_n = 1'b0;
                // ALU carry here is the one registered after LO.
                state_nx = fix_now ? S_FIX : S_DONE;
            end
            S_FIX: begin
                drv_a    = res_hi;
                drv_b    = 8'h01;
                drv_sub  = op_q;
                drv_en_n = 1'b0;
                state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= 16'h0000;
            b_q    <= 16'h0000;
            op_q   <= OP_ADD;
            res_lo <= 8'h00;
            res_hi <= 8'h00;
            c_lo   <= 1'b0;
            c_hi   <= 1'b0;
            result <= 16'h0000;
            cout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op_sub;
                    end
                end
                S_LO: begin
                    res_lo <= alu.alu_dbus;
                end
                S_HI: begin
                    res_hi <= alu.alu_dbus;
                    c_lo   <= alu.alu_carry;
                end
                S_FIX: begin
                    res_hi <= alu.alu_dbus;
                    c_hi   <= alu.alu_carry;
                end
                S_DONE: begin
                    // ALU carry now holds the last enabled pass:
                    // fix-up byte if FIX ran, else high byte.
                    result <= {res_hi, res_lo};
                    cout   <= carry_combine(op_q, fix, c_hi,
                                            alu.alu_carry);
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: scoreboard bench for alu_seq16 with a behavioral
// 8-bit ALU on the bus and directed hand-computed vectors.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        op_sub = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        cout;

    alu_seq16_if bus ();

    alu_seq16 dut (
        .clk    (clk),
        .reset  (rst_n),
        .req    (req),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .alu    (bus)
    );

    always #5 clk = ~clk;

    // Behavioral 8-bit ALU: combinational bus, carry registered
    // on every edge where the enable is low.
    logic [8:0] alu_sum;
    logic       alu_c_q;

    always_comb begin
        if (bus.alu_sub)
            alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        else
            alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    end

    assign bus.alu_dbus  = bus.alu_assert_bar_e ? 8'h00 : alu_sum[7:0];
    assign bus.alu_carry = alu_c_q;

    always_ff @(posedge clk) begin
        if (!bus.alu_assert_bar_e)
            alu_c_q <= bus.alu_sub ? ~alu_sum[8] : alu_sum[8];
    end

    typedef struct {
        logic [15:0] res;
        logic        c;
        int          lat;
        int          t0;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest accepted request.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done=1 want 0");
            end else begin
                e = sb.pop_front();
                check({e.nm, "_result"}, {16'h0, result}, {16'h0, e.res});
                check({e.nm, "_cout"}, {31'h0, cout}, {31'h0, e.c});
                check({e.nm, "_latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    // Presents a request and records the expectation once the
    // sequencer is seen ready, i.e. on the accepting cycle.
    task automatic issue(input string nm, input logic op,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] r, input logic c,
                         input int lat);
        int guard;
        @(negedge clk);
        req    = 1'b1;
        op_sub = op;
        a      = x;
        b      = y;
        guard  = 0;
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: got ready=0 want 1", nm);
        end else begin
            sb.push_back('{r, c, lat, cyc, nm});
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int guard;
        @(negedge clk);
        req   = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
        guard = 0;
        while (sb.size() != 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0",
                     sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", {16'h0, result}, 32'h0);
        check("rst_cout", {31'h0, cout}, 32'h0);
        check("rst_alu_a", {24'h0, bus.alu_a}, 32'h0);
        check("rst_alu_b", {24'h0, bus.alu_b}, 32'h0);
        check("rst_alu_sub", {31'h0, bus.alu_sub}, 32'h0);
        check("rst_bar_e", {31'h0, bus.alu_assert_bar_e}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_nofix", 1'b0, 16'h1234, 16'h0101, 16'h1335, 1'b0, 4);
        drain();
        issue("add_fix", 1'b0, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 5);
        drain();
        issue("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 5);
        drain();
        issue("sub_fix", 1'b1, 16'h1300, 16'h0001, 16'h12FF, 1'b1, 5);
        drain();
        issue("sub_under", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 5);
        drain();
        issue("sub_nofix", 1'b1, 16'h5678, 16'h1234, 16'h4444, 1'b1, 4);
        drain();
        issue("add_hicarry", 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 4);
        drain();
        issue("sub_hiborrow", 1'b1, 16'h0100, 16'h0200, 16'hFF00, 1'b0, 4);
        drain();

        // req held high: each issue changes operands while busy.
        issue("b2b_0", 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 4);
        issue("b2b_1", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 5);
        issue("b2b_2", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 5);
        issue("b2b_3", 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 4);
        drain();

        // Abort in HI: no completion may follow.
        @(negedge clk);
        req    = 1'b1;
        op_sub = 1'b0;
        a      = 16'h1234;
        b      = 16'h0101;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("hi_busy", {31'h0, ready}, 32'h0);
        check("hi_bar_e", {31'h0, bus.alu_assert_bar_e}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, ready}, 32'h1);
        check("abort_bar_e", {31'h0, bus.alu_assert_bar_e}, 32'h1);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_result", {16'h0, result}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_idle", {31'h0, ready}, 32'h1);

        issue("post_rst", 1'b0, 16'h1234, 16'h0101, 16'h1335, 1'b0, 4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
